// File: rtl/confreg_sram_if.sv
// Data-port SRAM bus between the core (master) and a memory-mapped responder (slave).
// The slave returns rdata registered, one cycle after the request.
interface confreg_sram_if;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport master (output sram_en, sram_wen, sram_addr, sram_wdata, input sram_rdata);
  modport slave  (input sram_en, sram_wen, sram_addr, sram_wdata, output sram_rdata);
endinterface

// File: rtl/confreg_sram.sv
// Confreg responder: scratch, LED, synced switches, free-running timer and a TX byte FIFO.
// Reads return registered data one cycle later; no stall path, a request is accepted every cycle.
module confreg_sram #(
  parameter logic [15:0] BASE_HI    = 16'hBFAF,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  confreg_sram_if.slave  bus,
  output logic [15:0]    led,
  input  logic [7:0]     switch,
  output logic           tx_valid,
  output logic [7:0]     tx_data,
  input  logic           tx_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // Word offsets (byte offset >> 2)
  localparam logic [13:0] OFF_SCRATCH = 14'h2000;
  localparam logic [13:0] OFF_LED     = 14'h2001;
  localparam logic [13:0] OFF_SWITCH  = 14'h2002;
  localparam logic [13:0] OFF_TIMER   = 14'h2003;
  localparam logic [13:0] OFF_TXDATA  = 14'h2004;
  localparam logic [13:0] OFF_TXSTAT  = 14'h2005;

  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   scratch_q, scratch_d;
  logic [15:0]   led_q, led_d;
  logic [31:0]   timer_q, timer_d;
  logic [7:0]    sw_meta_q, sw_sync_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          hit, rd, wr, full, empty, pop, push, push_ok;
  logic [13:0]   off;
  logic [31:0]   rd_val, status, wmerge_timer, wmerge_scratch, wmerge_led;
  logic          unused_addr_lsb;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  assign unused_addr_lsb = ^bus.sram_addr[1:0];

  assign hit   = bus.sram_en && (bus.sram_addr[31:16] == BASE_HI);
  assign off   = bus.sram_addr[15:2];
  assign rd    = bus.sram_en && (bus.sram_wen == 4'b0000);
  assign wr    = hit && (bus.sram_wen != 4'b0000);

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign tx_valid = !empty;
  assign tx_data  = mem_q[rptr_q];
  assign pop      = tx_valid && tx_ready;
  assign push     = wr && (off == OFF_TXDATA) && bus.sram_wen[0];
  assign push_ok  = push && (!full || pop);

  assign status = {23'b0, ovf_q, 1'b0, 5'(count_q), empty, full};

  assign wmerge_timer   = merge(timer_q, bus.sram_wdata, bus.sram_wen);
  assign wmerge_scratch = merge(scratch_q, bus.sram_wdata, bus.sram_wen);
  assign wmerge_led     = merge({16'b0, led_q}, bus.sram_wdata, bus.sram_wen);

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_SCRATCH: rd_val = scratch_q;
      OFF_LED:     rd_val = {16'b0, led_q};
      OFF_SWITCH:  rd_val = {24'b0, sw_sync_q};
      OFF_TIMER:   rd_val = timer_q;
      OFF_TXSTAT:  rd_val = status;
      default:     rd_val = '0;
    endcase
  end

  always_comb begin
    rdata_d   = rdata_q;
    scratch_d = scratch_q;
    led_d     = led_q;
    timer_d   = timer_q + 32'd1;
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;

    if (rd) rdata_d = hit ? rd_val : 32'b0;

    if (wr && off == OFF_SCRATCH) scratch_d = wmerge_scratch;
    if (wr && off == OFF_LED)     led_d     = wmerge_led[15:0];
    if (wr && off == OFF_TIMER)   timer_d   = wmerge_timer;

    if (pop)     rptr_d = rptr_q + PW'(1);
    if (push_ok) wptr_d = wptr_q + PW'(1);
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push_ok) count_d = count_q - CW'(1);

    // Clearing wins over a same-cycle overflow
    if (wr && off == OFF_TXSTAT) ovf_d = 1'b0;
    else if (push && !push_ok)   ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q   <= '0;
      scratch_q <= '0;
      led_q     <= '0;
      timer_q   <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rdata_q   <= rdata_d;
      scratch_q <= scratch_d;
      led_q     <= led_d;
      timer_q   <= timer_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      if (push_ok) mem_q[wptr_q] <= bus.sram_wdata[7:0];
    end
  end

  assign bus.sram_rdata = rdata_q;
  assign led            = led_q;
endmodule
